// File: rtl/fp_convert_sequencer_if.sv
// Beat-input and result-output streams of the double-to-float front end.
// The master side is the upstream producer and downstream consumer; the slave side is the sequencer.
interface fp_convert_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_rounding;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic [3:0]  out_flags;

    modport master (
        output in_valid, in_data, in_last, in_rounding, out_ready,
        input  in_ready, out_valid, out_float, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_last, in_rounding, out_ready,
        output in_ready, out_valid, out_float, out_flags
    );
endinterface

// File: rtl/fp_convert_sequencer.sv
// Front-end sequencer: builds a double from two beats, runs the converter once, returns the float.
// Latency: out_valid from edge E1+k after the high-word accept; in_ready low from accept until result handshake.
module fp_convert_sequencer #(
    parameter int          TIMEOUT_CYCLES = 8,
    parameter logic [31:0] TIMEOUT_RESULT = 32'h7FC00000
) (
    input  logic                         clk,
    input  logic                         reset,
    fp_convert_sequencer_if.slave        stream,
    output logic                         conv_reset,
    output logic [63:0]                  conv_double,
    output logic [1:0]                   conv_rounding,
    input  logic                         conv_done,
    input  logic [31:0]                  conv_float,
    input  logic                         conv_nan,
    input  logic                         conv_overflow,
    input  logic                         conv_underflow,
    input  logic                         clear_sticky,
    output logic [4:0]                   sticky_flags,
    output logic                         busy
);

    typedef enum logic [2:0] {
        IDLE_LO = 3'd0,
        WAIT_HI = 3'd1,
        KICK    = 3'd2,
        RUN     = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wd_cnt;
    logic       accept;
    logic       proto_err;
    logic       wd_expired;
    logic [4:0] flag_set;

    always_comb begin
        accept     = stream.in_valid & stream.in_ready;
        proto_err  = accept & (((state == IDLE_LO) &  stream.in_last) |
                               ((state == WAIT_HI) & ~stream.in_last));
        wd_expired = (wd_cnt == WD_LAST);
        flag_set   = '0;
        flag_set[4] = proto_err;
        if (state == RUN) begin
            if (conv_done)
                flag_set[2:0] = {conv_nan, conv_overflow, conv_underflow};
            else if (wd_expired)
                flag_set[3:2] = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE_LO;
            stream.in_ready  <= 1'b1;
            conv_reset       <= 1'b0;
            conv_double      <= '0;
            conv_rounding    <= '0;
            stream.out_valid <= 1'b0;
            stream.out_float <= '0;
            stream.out_flags <= '0;
            sticky_flags     <= '0;
            busy             <= 1'b0;
            wd_cnt           <= '0;
        end else begin
            // A set event on the clearing edge survives only in its own bits.
            sticky_flags <= (clear_sticky ? 5'd0 : sticky_flags) | flag_set;
            case (state)
                IDLE_LO: begin
                    if (accept && !stream.in_last) begin
                        conv_double[31:0] <= stream.in_data;
                        state             <= WAIT_HI;
                        busy              <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (accept) begin
                        if (stream.in_last) begin
                            conv_double[63:32] <= stream.in_data;
                            conv_rounding      <= stream.in_rounding;
                            stream.in_ready    <= 1'b0;
                            state              <= KICK;
                        end else begin
                            conv_double[31:0]  <= stream.in_data;
                        end
                    end
                end
                KICK: begin
                    wd_cnt     <= '0;
                    conv_reset <= 1'b1;
                    state      <= RUN;
                end
                RUN: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (conv_done) begin
                        stream.out_float <= conv_float;
                        stream.out_flags <= {1'b0, conv_nan, conv_overflow, conv_underflow};
                        stream.out_valid <= 1'b1;
                        conv_reset       <= 1'b0;
                        state            <= HOLD;
                    end else if (wd_expired) begin
                        stream.out_float <= TIMEOUT_RESULT;
                        stream.out_flags <= 4'b1100;
                        stream.out_valid <= 1'b1;
                        conv_reset       <= 1'b0;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (stream.out_valid && stream.out_ready) begin
                        stream.out_valid <= 1'b0;
                        stream.in_ready  <= 1'b1;
                        busy             <= 1'b0;
                        state            <= IDLE_LO;
                    end
                end
                default: begin
                    state           <= IDLE_LO;
                    stream.in_ready <= 1'b1;
                    conv_reset      <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule
